// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson/ring phase generator with direction, parallel load,
// illegal-state self-correction, binary phase index and wrap/err pulses.
module johnson_counter_gen #(
  parameter  int N  = 4,
  localparam int PW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  out,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          err
);

  logic [N-1:0]  out_q,  out_d;
  logic          mode_q, mode_d;
  logic          wrap_q, wrap_d;
  logic          err_q,  err_d;
  logic          legal;
  logic [PW-1:0] phase_dec;
  logic [PW-1:0] last_phase;

  // Mask with the low k bits set (k may equal N).
  function automatic logic [N-1:0] fill_ones(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (i < k);
    end
    return m;
  endfunction

  function automatic logic [N-1:0] reset_pattern(input logic ring);
    return ring ? N'(1) : '0;
  endfunction

  // Johnson codes are either k ones filled from the LSB or j zeros filled
  // from the LSB with ones above; ring codes are one-hot.
  always_comb begin
    legal     = 1'b0;
    phase_dec = '0;
    if (mode_q) begin
      for (int i = 0; i < N; i++) begin
        if (out_q == (N'(1) << i)) begin
          legal     = 1'b1;
          phase_dec = PW'(i);
        end
      end
    end else begin
      for (int k = 0; k <= N; k++) begin
        if (out_q == fill_ones(k)) begin
          legal     = 1'b1;
          phase_dec = PW'(k);
        end
      end
      for (int j = 1; j < N; j++) begin
        if (out_q == ~fill_ones(j)) begin
          legal     = 1'b1;
          phase_dec = PW'(N + j);
        end
      end
    end
  end

  assign last_phase = mode_q ? PW'(N - 1) : PW'(2*N - 1);

  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      out_d  = load_val;
      mode_d = mode;
    end else if (mode != mode_q) begin
      out_d  = reset_pattern(mode);
      mode_d = mode;
    end else if (!legal) begin
      out_d = reset_pattern(mode_q);
      err_d = 1'b1;
    end else if (en) begin
      if (mode_q) begin
        out_d = up ? {out_q[N-2:0], out_q[N-1]} : {out_q[0], out_q[N-1:1]};
      end else begin
        out_d = up ? {out_q[N-2:0], ~out_q[N-1]} : {~out_q[0], out_q[N-1:1]};
      end
      wrap_d = up ? (phase_dec == last_phase) : (phase_dec == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out   = out_q;
  assign phase = phase_dec;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Directed scoreboard bench for johnson_counter_gen at N = 4.
module tb_johnson_counter_gen;

  localparam int N  = 4;
  localparam int PW = $clog2(2*N);

  logic          clk;
  logic          rst;
  logic          en;
  logic          up;
  logic          mode;
  logic          load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  out;
  logic [PW-1:0] phase;
  logic          wrap;
  logic          err;

  typedef struct {
    string         tag;
    logic [N-1:0]  out;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  johnson_counter_gen #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .phase    (phase),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops the oldest expectation and compares it against the live outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty got 0 entries want at least 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (out === e.out) else begin
      errors++;
      $error("[TB] FAIL %s.out got %b want %b", e.tag, out, e.out);
    end
    checks++;
    assert (phase === e.phase) else begin
      errors++;
      $error("[TB] FAIL %s.phase got %0d want %0d", e.tag, phase, e.phase);
    end
    checks++;
    assert (wrap === e.wrap) else begin
      errors++;
      $error("[TB] FAIL %s.wrap got %b want %b", e.tag, wrap, e.wrap);
    end
    checks++;
    assert (err === e.err) else begin
      errors++;
      $error("[TB] FAIL %s.err got %b want %b", e.tag, err, e.err);
    end
  endtask

  task automatic pushExp(input string tag, input logic [N-1:0] o,
                         input logic [PW-1:0] p, input logic w, input logic e);
    exp_t x;
    x.tag   = tag;
    x.out   = o;
    x.phase = p;
    x.wrap  = w;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Drives one cycle of inputs, records the expected result, clocks, checks.
  task automatic applyStimulus(input string tag, input logic i_en, input logic i_up,
                               input logic i_mode, input logic i_load,
                               input logic [N-1:0] i_lval, input logic [N-1:0] e_out,
                               input logic [PW-1:0] e_ph, input logic e_wrap,
                               input logic e_err);
    en       = i_en;
    up       = i_up;
    mode     = i_mode;
    load     = i_load;
    load_val = i_lval;
    pushExp(tag, e_out, e_ph, e_wrap, e_err);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #20000;
    errors++;
    $display("[TB] FAIL timeout got still running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    mode     = 1'b0;
    load     = 1'b0;
    load_val = '0;

    #22;
    pushExp("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    checkOutput();
    rst = 1'b1;
    #2;

    // Johnson forward through a full sequence and one step past wrap
    applyStimulus("fwd1", 1, 1, 0, 0, 4'b0, 4'b0001, 3'd1, 0, 0);
    applyStimulus("fwd2", 1, 1, 0, 0, 4'b0, 4'b0011, 3'd2, 0, 0);
    applyStimulus("fwd3", 1, 1, 0, 0, 4'b0, 4'b0111, 3'd3, 0, 0);
    applyStimulus("fwd4", 1, 1, 0, 0, 4'b0, 4'b1111, 3'd4, 0, 0);
    applyStimulus("fwd5", 1, 1, 0, 0, 4'b0, 4'b1110, 3'd5, 0, 0);
    applyStimulus("fwd6", 1, 1, 0, 0, 4'b0, 4'b1100, 3'd6, 0, 0);
    applyStimulus("fwd7", 1, 1, 0, 0, 4'b0, 4'b1000, 3'd7, 0, 0);
    applyStimulus("fwd_wrap", 1, 1, 0, 0, 4'b0, 4'b0000, 3'd0, 1, 0);
    applyStimulus("fwd9", 1, 1, 0, 0, 4'b0, 4'b0001, 3'd1, 0, 0);
    applyStimulus("hold", 0, 1, 0, 0, 4'b0, 4'b0001, 3'd1, 0, 0);

    // Johnson reverse, wrapping from phase 0 to 7
    applyStimulus("rev0", 1, 0, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0);
    applyStimulus("rev_wrap", 1, 0, 0, 0, 4'b0, 4'b1000, 3'd7, 1, 0);
    applyStimulus("rev6", 1, 0, 0, 0, 4'b0, 4'b1100, 3'd6, 0, 0);
    applyStimulus("rev5", 1, 0, 0, 0, 4'b0, 4'b1110, 3'd5, 0, 0);

    // Illegal load is visible one cycle then corrected, step lost
    applyStimulus("ill_load", 1, 1, 0, 1, 4'b0101, 4'b0101, 3'd0, 0, 0);
    applyStimulus("ill_fix", 1, 1, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 1);
    applyStimulus("ill_resume", 1, 1, 0, 0, 4'b0, 4'b0001, 3'd1, 0, 0);

    // Priority: load over step, mode change over step
    applyStimulus("load_en", 1, 1, 0, 1, 4'b0011, 4'b0011, 3'd2, 0, 0);
    applyStimulus("mode_sw", 1, 1, 1, 0, 4'b0, 4'b0001, 3'd0, 0, 0);

    // Ring forward and reverse
    applyStimulus("ring1", 1, 1, 1, 0, 4'b0, 4'b0010, 3'd1, 0, 0);
    applyStimulus("ring2", 1, 1, 1, 0, 4'b0, 4'b0100, 3'd2, 0, 0);
    applyStimulus("ring3", 1, 1, 1, 0, 4'b0, 4'b1000, 3'd3, 0, 0);
    applyStimulus("ring_wrap", 1, 1, 1, 0, 4'b0, 4'b0001, 3'd0, 1, 0);
    applyStimulus("ring_rev_wrap", 1, 0, 1, 0, 4'b0, 4'b1000, 3'd3, 1, 0);
    applyStimulus("ring_rev2", 1, 0, 1, 0, 4'b0, 4'b0100, 3'd2, 0, 0);

    // Illegal ring load corrects to 0001
    applyStimulus("ring_ill", 0, 1, 1, 1, 4'b0011, 4'b0011, 3'd0, 0, 0);
    applyStimulus("ring_fix", 1, 1, 1, 0, 4'b0, 4'b0001, 3'd0, 0, 1);

    // Load with mode change takes load_val in the new mode
    applyStimulus("load_mode", 1, 1, 0, 1, 4'b0111, 4'b0111, 3'd3, 0, 0);
    applyStimulus("after_lm", 1, 1, 0, 0, 4'b0, 4'b1111, 3'd4, 0, 0);
    applyStimulus("reload", 0, 1, 0, 1, 4'b0111, 4'b0111, 3'd3, 0, 0);

    // Asynchronous reset mid-count, held across enabled edges
    #2;
    rst = 1'b0;
    en  = 1'b1;
    #1;
    pushExp("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("rst_hold1", 1, 1, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0);
    applyStimulus("rst_hold2", 1, 1, 0, 0, 4'b0, 4'b0000, 3'd0, 0, 0);

    // Ring mode held through reset: first edge applies the ring pattern
    mode = 1'b1;
    #1;
    pushExp("ring_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
    checkOutput();
    rst = 1'b1;
    applyStimulus("ring_first", 1, 1, 1, 0, 4'b0, 4'b0001, 3'd0, 0, 0);
    applyStimulus("ring_step", 1, 1, 1, 0, 4'b0, 4'b0010, 3'd1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
